// File: rtl/mem_bus_adapter.sv
// ============================================================================
// Module      : mem_bus_adapter
// Description : Bridges a CPU's fetch/load/store requests onto a single
//               Avalon-MM style master port, one transfer at a time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_adapter (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        stall,
    output logic        proto_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUS     = 2'd1;
    localparam logic [1:0] c_DONE    = 2'd2;

    localparam logic [1:0] c_K_FETCH = 2'd0;
    localparam logic [1:0] c_K_READ  = 2'd1;
    localparam logic [1:0] c_K_WRITE = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [1:0]  r_kind;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_proto_err;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;

    logic        w_any_req;
    logic        w_multi_req;
    logic        w_accept;
    logic        w_stall;
    logic        w_rd;
    logic        w_wr;
    logic        w_done_xfer;
    logic [1:0]  w_req_kind;
    logic [29:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [3:0]  w_req_be;
    logic        w_unused_addr_bits;

    // Byte offsets never reach the bus; the word address is all that is kept.
    assign w_unused_addr_bits = ^{instr_address[1:0], data_address[1:0]};

    assign w_any_req   = fetch_req | data_read | data_write;
    assign w_multi_req = (fetch_req & data_read) | (fetch_req & data_write) |
                         (data_read & data_write);

    always_comb begin
        w_req_kind  = c_K_FETCH;
        w_req_addr  = instr_address[31:2];
        w_req_wdata = 32'h0;
        w_req_be    = 4'hF;
        if (data_write) begin
            w_req_kind  = c_K_WRITE;
            w_req_addr  = data_address[31:2];
            w_req_wdata = data_writedata;
            w_req_be    = data_byteenable;
        end else if (data_read) begin
            w_req_kind  = c_K_READ;
            w_req_addr  = data_address[31:2];
            w_req_wdata = data_writedata;
            w_req_be    = data_byteenable;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_rd        = 1'b0;
        w_wr        = 1'b0;
        w_accept    = 1'b0;
        w_done_xfer = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_stall  = w_any_req;
                w_accept = w_any_req;
                if (w_any_req) begin
                    w_state_nxt = c_BUS;
                end
            end
            c_BUS: begin
                w_stall = 1'b1;
                w_rd    = (r_kind != c_K_WRITE);
                w_wr    = (r_kind == c_K_WRITE);
                if (!avm_waitrequest) begin
                    w_done_xfer = 1'b1;
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Request latches only move on acceptance, so the bus side stays frozen
    // for as long as the slave holds waitrequest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kind  <= c_K_FETCH;
            r_addr  <= 30'h0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
        end else if (w_accept) begin
            r_kind  <= w_req_kind;
            r_addr  <= w_req_addr;
            r_wdata <= w_req_wdata;
            r_be    <= w_req_be;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (r_state == c_IDLE && w_multi_req) begin
            r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_rdata <= 32'h0;
            r_data_rdata  <= 32'h0;
        end else if (w_done_xfer) begin
            if (r_kind == c_K_FETCH) begin
                r_instr_rdata <= avm_readdata;
            end else if (r_kind == c_K_READ) begin
                r_data_rdata <= avm_readdata;
            end
        end
    end

    assign stall          = w_stall;
    assign proto_err      = r_proto_err;
    assign instr_readdata = r_instr_rdata;
    assign data_readdata  = r_data_rdata;
    assign avm_read       = w_rd;
    assign avm_write      = w_wr;
    assign avm_address    = {r_addr, 2'b00};
    assign avm_writedata  = r_wdata;
    assign avm_byteenable = r_be;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_adapter.sv
// ============================================================================
// Module      : tb_mem_bus_adapter
// Description : Directed self-checking bench for mem_bus_adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_adapter;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        stall;
    logic        proto_err;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int vectors;
    int miscompares;

    mem_bus_adapter dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .stall           (stall),
        .proto_err       (proto_err),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " avm_read"},       {31'h0, avm_read},  32'h0);
        check({tag, " avm_write"},      {31'h0, avm_write}, 32'h0);
        check({tag, " avm_address"},    avm_address,        32'h0);
        check({tag, " avm_writedata"},  avm_writedata,      32'h0);
        check({tag, " avm_byteenable"}, {28'h0, avm_byteenable}, 32'h0);
        check({tag, " instr_readdata"}, instr_readdata,     32'h0);
        check({tag, " data_readdata"},  data_readdata,      32'h0);
        check({tag, " proto_err"},      {31'h0, proto_err}, 32'h0);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        fetch_req       = 1'b0;
        instr_address   = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_writedata  = 32'h0;
        data_byteenable = 4'h0;
        avm_readdata    = 32'h0;
        avm_waitrequest = 1'b0;

        // Reset state
        sample();
        check_reset_values("rst");
        check("rst stall", {31'h0, stall}, 32'h0);
        next_cycle();
        reset = 1'b0;

        // Fetch, zero wait
        fetch_req     = 1'b1;
        instr_address = 32'hBFC0_0000;
        avm_readdata  = 32'h2402_0005;
        sample();
        check("f0 idle stall", {31'h0, stall},    32'h1);
        check("f0 idle read",  {31'h0, avm_read}, 32'h0);
        next_cycle();
        sample();
        check("f0 bus read",  {31'h0, avm_read},  32'h1);
        check("f0 bus write", {31'h0, avm_write}, 32'h0);
        check("f0 bus addr",  avm_address,        32'hBFC0_0000);
        check("f0 bus be",    {28'h0, avm_byteenable}, 32'hF);
        check("f0 bus stall", {31'h0, stall},     32'h1);
        next_cycle();
        fetch_req = 1'b0;
        sample();
        check("f0 done stall", {31'h0, stall},    32'h0);
        check("f0 done read",  {31'h0, avm_read}, 32'h0);
        check("f0 instr",      instr_readdata,    32'h2402_0005);
        check("f0 data",       data_readdata,     32'h0);
        next_cycle();

        // Load with three wait cycles
        data_read       = 1'b1;
        data_address    = 32'h0000_1006;
        data_byteenable = 4'h3;
        avm_waitrequest = 1'b1;
        avm_readdata    = 32'h1111_1111;
        sample();
        check("ld idle stall", {31'h0, stall}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 3) begin
                avm_waitrequest = 1'b0;
                avm_readdata    = 32'hCAFE_F00D;
            end
            sample();
            check("ld bus read",  {31'h0, avm_read}, 32'h1);
            check("ld bus addr",  avm_address,       32'h0000_1004);
            check("ld bus be",    {28'h0, avm_byteenable}, 32'h3);
            check("ld bus stall", {31'h0, stall},    32'h1);
            check("ld bus hold",  data_readdata,     32'h0);
        end
        next_cycle();
        data_read = 1'b0;
        sample();
        check("ld done stall", {31'h0, stall},    32'h0);
        check("ld done read",  {31'h0, avm_read}, 32'h0);
        check("ld data",       data_readdata,     32'hCAFE_F00D);
        check("ld instr kept", instr_readdata,    32'h2402_0005);
        next_cycle();

        // Store
        data_write      = 1'b1;
        data_address    = 32'h0000_2000;
        data_writedata  = 32'hDEAD_BEEF;
        data_byteenable = 4'hC;
        avm_readdata    = 32'h5555_5555;
        sample();
        check("st idle stall", {31'h0, stall}, 32'h1);
        next_cycle();
        sample();
        check("st bus write", {31'h0, avm_write}, 32'h1);
        check("st bus read",  {31'h0, avm_read},  32'h0);
        check("st bus addr",  avm_address,        32'h0000_2000);
        check("st bus wdata", avm_writedata,      32'hDEAD_BEEF);
        check("st bus be",    {28'h0, avm_byteenable}, 32'hC);
        next_cycle();
        data_write = 1'b0;
        sample();
        check("st done write", {31'h0, avm_write}, 32'h0);
        check("st data kept",  data_readdata,      32'hCAFE_F00D);
        check("st instr kept", instr_readdata,     32'h2402_0005);
        check("st no perr",    {31'h0, proto_err}, 32'h0);
        next_cycle();

        // Concurrent load + fetch
        data_read       = 1'b1;
        fetch_req       = 1'b1;
        data_address    = 32'h0000_3008;
        instr_address   = 32'h0000_4000;
        data_byteenable = 4'hF;
        avm_readdata    = 32'h1234_5678;
        sample();
        check("cc idle stall", {31'h0, stall}, 32'h1);
        next_cycle();
        sample();
        check("cc bus read", {31'h0, avm_read}, 32'h1);
        check("cc bus addr", avm_address,        32'h0000_3008);
        check("cc perr",     {31'h0, proto_err}, 32'h1);
        next_cycle();
        data_read = 1'b0;
        fetch_req = 1'b0;
        sample();
        check("cc data",       data_readdata,  32'h1234_5678);
        check("cc instr kept", instr_readdata, 32'h2402_0005);
        repeat (10) next_cycle();
        sample();
        check("cc perr sticky", {31'h0, proto_err}, 32'h1);
        check("cc no fetch",    {31'h0, avm_read},  32'h0);
        next_cycle();

        // Reset in the middle of a waited fetch
        fetch_req       = 1'b1;
        instr_address   = 32'h0000_8000;
        avm_waitrequest = 1'b1;
        next_cycle();
        sample();
        check("rb bus read", {31'h0, avm_read}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("rb");
        check("rb stall", {31'h0, stall}, 32'h1);
        next_cycle();
        reset           = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h0BAD_C0DE;
        sample();
        check("rb idle stall", {31'h0, stall}, 32'h1);
        next_cycle();
        sample();
        check("rb bus read", {31'h0, avm_read}, 32'h1);
        check("rb bus addr", avm_address,       32'h0000_8000);
        next_cycle();
        fetch_req = 1'b0;
        sample();
        check("rb instr", instr_readdata, 32'h0BAD_C0DE);
        next_cycle();

        // Back-to-back fetch then load
        fetch_req     = 1'b1;
        instr_address = 32'h0000_0100;
        avm_readdata  = 32'hAAAA_0001;
        sample();
        check("bb f idle stall", {31'h0, stall}, 32'h1);
        next_cycle();
        sample();
        check("bb f bus addr", avm_address, 32'h0000_0100);
        next_cycle();
        fetch_req       = 1'b0;
        data_read       = 1'b1;
        data_address    = 32'h0000_0204;
        data_byteenable = 4'hF;
        avm_readdata    = 32'hBBBB_0002;
        sample();
        check("bb done stall", {31'h0, stall},    32'h0);
        check("bb done read",  {31'h0, avm_read}, 32'h0);
        check("bb instr",      instr_readdata,    32'hAAAA_0001);
        next_cycle();
        sample();
        check("bb l idle stall", {31'h0, stall}, 32'h1);
        next_cycle();
        sample();
        check("bb l bus read",  {31'h0, avm_read}, 32'h1);
        check("bb l bus addr",  avm_address,       32'h0000_0204);
        check("bb l bus stall", {31'h0, stall},    32'h1);
        next_cycle();
        data_read = 1'b0;
        sample();
        check("bb l data",  data_readdata,      32'hBBBB_0002);
        check("bb l stall", {31'h0, stall},     32'h0);
        check("bb no perr", {31'h0, proto_err}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_bus_adapter.md
MEM_BUS_ADAPTER -- requirements
Module: mem_bus_adapter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port `clk` SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 The port `reset` SHALL be an input, 1 bit wide, asynchronous and active-high; it clears all state immediately.
REQ-004 fetch_req  in  1  instruction fetch requested (high while CPU in fetch state).
REQ-005 instr_address  in  32  fetch byte address.
REQ-006 instr_readdata  out  32  registered fetched instruction word.
REQ-007 data_read  in  1  load requested.
REQ-008 data_write  in  1  store requested.
REQ-009 data_address  in  32  load/store byte address.
REQ-010 data_writedata  in  32  store data.
REQ-011 data_byteenable  in  4  store/load byte lanes.
REQ-012 data_readdata  out  32  registered load data.
REQ-013 stall  out  1  CPU hold; high while an accepted request is incomplete.
REQ-014 proto_err  out  1  sticky flag for illegal concurrent requests.
REQ-015 avm_address  out  32  bus word address.
REQ-016 avm_read  out  1  bus read strobe.
REQ-017 avm_write  out  1  bus write strobe.
REQ-018 avm_writedata  out  32  bus write data.
REQ-019 avm_byteenable  out  4  bus byte lanes.
REQ-020 avm_readdata  in  32  bus read data, valid when avm_read high and avm_waitrequest low.
REQ-021 avm_waitrequest  in  1  slave not ready; master holds all outputs stable.

Function
REQ-022 The FSM SHALL have states IDLE, BUS and DONE.
REQ-023 IDLE: when any of fetch_req/data_read/data_write is high, the block SHALL latch kind, address, writedata and byteenable, and go to BUS next cycle.
REQ-024 IDLE: stall SHALL be combinationally high whenever a request input is high; otherwise low.
REQ-025 Request priority SHALL be data_write > data_read > fetch_req; exactly one transaction is issued per acceptance.
REQ-026 Any two request inputs high together in IDLE SHALL set proto_err (sticky until reset); the lower-priority request is dropped.
REQ-027 BUS: avm_read or avm_write SHALL be high per the latched kind; avm_address = latched address with bits [1:0] forced to 0; stall = 1.
REQ-028 Fetches SHALL drive avm_byteenable = 4'b1111; data accesses SHALL drive the latched byteenable.
REQ-029 BUS: all avm_* outputs SHALL stay constant while avm_waitrequest is high; no timeout.
REQ-030 BUS: on a cycle with avm_waitrequest low, the transfer completes; a read captures avm_readdata into instr_readdata (fetch) or data_readdata (load); go to DONE.
REQ-031 A write SHALL leave both readdata registers unchanged.
REQ-032 DONE: stall = 0, avm_read = avm_write = 0, request inputs ignored, go to IDLE next cycle; minimum request-to-release latency is 2 cycles (IDLE, BUS with waitrequest low, then DONE).
REQ-033 instr_readdata and data_readdata SHALL hold their value until overwritten by a later completed read of the same kind.
REQ-034 avm_read and avm_write SHALL never be high simultaneously and SHALL be low outside BUS.

Reset
REQ-035 While reset is high: state IDLE, avm_read = avm_write = 0, avm_address/avm_writedata = 0, avm_byteenable = 0, instr_readdata = data_readdata = 0, proto_err = 0, all latches cleared.
REQ-036 Reset asserted in BUS SHALL abort the transfer immediately (strobes low same cycle, asynchronously), with no capture.
REQ-037 After reset, stall SHALL follow REQ-024 only.

Verification
REQ-038 Fetch, zero wait: fetch_req = 1, instr_address = 0xBFC00000, waitrequest = 0, readdata = 0x24020005 -> avm_read for 1 cycle at 0xBFC00000, byteenable 0xF, stall high 2 cycles, instr_readdata = 0x24020005 in DONE.
REQ-039 Load, 3 wait cycles: data_read = 1, addr 0x1006, be 0x3 -> avm_address 0x1004 held 4 cycles, stall high 5 cycles, data_readdata = readdata on final cycle.
REQ-040 Store: data_write = 1, addr 0x2000, wdata 0xDEADBEEF, be 0xC -> one avm_write with those values; data_readdata and instr_readdata unchanged.
REQ-041 Concurrent requests: data_read and fetch_req both high -> only a read at data_address; proto_err = 1, still 1 after 10 idle cycles.
REQ-042 Reset mid-BUS: assert reset during waitrequest = 1 -> avm_read low in the same cycle, all outputs at REQ-035 values; the next fetch proceeds normally.
REQ-043 Back-to-back: fetch then load on consecutive acceptances -> DONE separates them; stall is low for exactly one cycle between the two transactions.
